prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer for the 9-bit core. Owns the program
//  counter, steps FETCH->EXEC(->MEM) per instruction, and gates the decoder's
//  RegWrEn/MemWrEn so register file and data memory write once per instruction.
//  Resolves jump/branch targets from the target LUT and raises Done on Ack.
// PARAMETERS
//  PC_W       10  program counter width; PC wraps modulo 2**PC_W
//  START_ADDR  0  PC loaded when a program is started
//  MEM_WAIT    1  cycles spent in MEM for load/store (legal range 1..15)
//  CNT_W      16  width of CycleCnt / InstrCnt
// PORTS
//  Clk        in   1      clock, all state on rising edge
//  Reset      in   1      synchronous, active-high
//  Start      in   1      level; begins program from START_ADDR when idle/done
//  Jump       in   1      decoded unconditional jump
//  BranchEn   in   1      decoded conditional branch
//  BranchCond in   1      ALU condition flag, valid in EXEC
//  LoadInst   in   1      decoded load
//  StoreInst  in   1      decoded store
//  RegWrEn    in   1      decoded register-write request
//  MemWrEn    in   1      decoded memory-write request
//  Ack        in   1      decoded end-of-program
//  TargAddr   in   PC_W   LUT target for the current instruction
//  ProgCtr    out  PC_W   instruction memory address
//  IrLoad     out  1      capture instruction register (FETCH only)
//  RegWrGate  out  1      qualified reg-file write strobe
//  MemWrGate  out  1      qualified data-memory write strobe
//  Busy       out  1      1 in FETCH/EXEC/MEM
//  Done       out  1      1 in DONE
//  CycleCnt   out  CNT_W  cycles since Start accepted, saturating
//  InstrCnt   out  CNT_W  retired instructions, saturating
// BEHAVIOUR
//  States: IDLE, FETCH, EXEC, MEM, DONE. Reset -> IDLE, ProgCtr=START_ADDR,
//   all strobes 0, Busy=0, Done=0, counters 0, MEM counter 0. Reset wins over
//   every other event, including mid-MEM; no write strobe in that cycle.
//  IDLE: Start=1 -> FETCH, ProgCtr=START_ADDR, counters cleared.
//  FETCH: IrLoad=1 for exactly one cycle -> EXEC. Start ignored while Busy.
//  EXEC: priority Ack > (LoadInst|StoreInst) > Jump > BranchEn&BranchCond > seq.
//   Ack: -> DONE, PC held, InstrCnt+1, no write strobes.
//   Load/Store: -> MEM, PC held, MEM counter=MEM_WAIT-1.
//   else: RegWrGate=RegWrEn; PC<=TargAddr (jump/taken) or PC+1; InstrCnt+1;
//   -> FETCH. Branch not taken (BranchCond=0) -> PC+1.
//  MEM: MemWrGate=MemWrEn&StoreInst in the first MEM cycle only.
//   RegWrGate=RegWrEn&LoadInst in the last MEM cycle only (counter==0).
//   Counter decrements each cycle; at 0: PC<=PC+1, InstrCnt+1, -> FETCH.
//   MEM_WAIT=1: both strobes in the single MEM cycle (store and load exclusive).
//  DONE: Done=1, outputs otherwise idle, PC held; Start=1 -> FETCH restart
//   exactly as from IDLE; Start=0 -> stay DONE.
//  CycleCnt +1 every cycle Busy=1; both counters saturate at all-ones.
//  PC+1 at 2**PC_W-1 wraps to 0. Decoder inputs only sampled in EXEC/MEM.
//  Strobes are Moore outputs of state and registered decode; one strobe max
//   per instruction per destination.
// TESTING
//  Reset, Start=1 one cycle -> ProgCtr=0, IrLoad pulse next cycle, Busy=1.
//  3 ALU ops then Ack -> 3 RegWrGate pulses, ProgCtr 0,1,2,3, Done=1,
//   InstrCnt=4, CycleCnt=8.
//  Jump TargAddr=0x2A -> ProgCtr=0x2A; branch BranchCond=0 -> PC+1, =1 -> target.
//  MEM_WAIT=3 load -> 3 MEM cycles, single RegWrGate in 3rd; store -> single
//   MemWrGate in 1st MEM cycle; PC advances by 1 after.
//  Reset asserted in MEM cycle 2 of store -> IDLE next cycle, no further strobe.
//  PC=0x3FF sequential -> 0x000; Start pulsed while Busy -> no effect;
//   Start in DONE -> restart at START_ADDR with counters cleared.

Source files
------------

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - fetch/execute/memory sequencer for the 9-bit core
// Owns the PC, steps FETCH->EXEC(->MEM) and qualifies decoder write requests.
module prog_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int MEM_WAIT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_jump,
  input  logic             i_branch_en,
  input  logic             i_branch_cond,
  input  logic             i_load_inst,
  input  logic             i_store_inst,
  input  logic             i_reg_wr_en,
  input  logic             i_mem_wr_en,
  input  logic             i_ack,
  input  logic [PC_W-1:0]  i_targ_addr,
  output logic [PC_W-1:0]  o_prog_ctr,
  output logic             o_ir_load,
  output logic             o_reg_wr_gate,
  output logic             o_mem_wr_gate,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [3:0]       MEM_LAST = 4'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [3:0]       r_mem_cnt;
  logic [3:0]       w_mem_cnt_next;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_busy;
  logic             w_cnt_clr;
  logic             w_instr_inc;
  logic             w_ir_load;
  logic             w_reg_wr;
  logic             w_mem_wr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_pc      <= START_PC;
      r_mem_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_pc_next;
      r_mem_cnt <= w_mem_cnt_next;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_pc_next      = r_pc;
    w_mem_cnt_next = r_mem_cnt;
    w_cnt_clr      = 1'b0;
    w_instr_inc    = 1'b0;
    w_ir_load      = 1'b0;
    w_reg_wr       = 1'b0;
    w_mem_wr       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_next_state   = S_FETCH;
          w_pc_next      = START_PC;
          w_mem_cnt_next = '0;
          w_cnt_clr      = 1'b1;
        end
      end
      S_FETCH: begin
        w_ir_load    = 1'b1;
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (i_ack) begin
          w_next_state = S_DONE;
          w_instr_inc  = 1'b1;
        end else if (i_load_inst || i_store_inst) begin
          w_next_state   = S_MEM;
          w_mem_cnt_next = MEM_LAST;
        end else begin
          w_reg_wr     = i_reg_wr_en;
          w_instr_inc  = 1'b1;
          w_next_state = S_FETCH;
          if (i_jump || (i_branch_en && i_branch_cond))
            w_pc_next = i_targ_addr;
          else
            w_pc_next = r_pc + PC_ONE;
        end
      end
      S_MEM: begin
        // Store writes on entry, load writes back on exit; both when MEM_WAIT=1.
        if (r_mem_cnt == MEM_LAST)
          w_mem_wr = i_mem_wr_en && i_store_inst;
        if (r_mem_cnt == 4'd0) begin
          w_reg_wr     = i_reg_wr_en && i_load_inst;
          w_pc_next    = r_pc + PC_ONE;
          w_instr_inc  = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_mem_cnt_next = r_mem_cnt - 4'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_busy = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEM);

  always_ff @(posedge i_clk) begin
    if (i_reset || w_cnt_clr) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (w_busy && (r_cycle_cnt != CNT_MAX))
        r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      if (w_instr_inc && (r_instr_cnt != CNT_MAX))
        r_instr_cnt <= r_instr_cnt + CNT_ONE;
    end
  end

  // Reset in the same cycle suppresses any strobe the current state would raise.
  assign o_ir_load     = w_ir_load && !i_reset;
  assign o_reg_wr_gate = w_reg_wr && !i_reset;
  assign o_mem_wr_gate = w_mem_wr && !i_reset;
  assign o_prog_ctr    = r_pc;
  assign o_busy        = w_busy;
  assign o_done        = (r_state == S_DONE);
  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instr_cnt   = r_instr_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer
// Runs a table of instructions through the sequencer, then reset/restart corner cases.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, jump, branch_en, branch_cond;
  logic        load_inst, store_inst, reg_wr_en, mem_wr_en, ack;
  logic [9:0]  targ_addr;
  logic [9:0]  prog_ctr;
  logic        ir_load, reg_wr_gate, mem_wr_gate, busy, done;
  logic [15:0] cycle_cnt, instr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prog_sequencer #(.PC_W(10), .START_ADDR(0), .MEM_WAIT(3), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_jump(jump),
    .i_branch_en(branch_en), .i_branch_cond(branch_cond),
    .i_load_inst(load_inst), .i_store_inst(store_inst),
    .i_reg_wr_en(reg_wr_en), .i_mem_wr_en(mem_wr_en), .i_ack(ack),
    .i_targ_addr(targ_addr), .o_prog_ctr(prog_ctr), .o_ir_load(ir_load),
    .o_reg_wr_gate(reg_wr_gate), .o_mem_wr_gate(mem_wr_gate),
    .o_busy(busy), .o_done(done), .o_cycle_cnt(cycle_cnt), .o_instr_cnt(instr_cnt)
  );

  typedef struct {
    logic       start, ack, ld, st, jump, br, cond, rwe, mwe;
    logic [9:0] targ;
    logic [9:0] exp_pc;
    int         exp_reg, exp_reg_at, exp_mem, exp_mem_at, exp_cyc;
  } vec_t;

  vec_t prog [0:16];

  function automatic vec_t mk(input logic s, a, l, t, j, b, c, r, m,
                              input logic [9:0] tg, input logic [9:0] pc,
                              input int nr, input int ar, input int nm, input int am,
                              input int cy);
    vec_t v;
    v.start = s; v.ack = a; v.ld = l; v.st = t; v.jump = j; v.br = b; v.cond = c;
    v.rwe = r; v.mwe = m; v.targ = tg; v.exp_pc = pc;
    v.exp_reg = nr; v.exp_reg_at = ar; v.exp_mem = nm; v.exp_mem_at = am; v.exp_cyc = cy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decode();
    start = 0; ack = 0; load_inst = 0; store_inst = 0; jump = 0;
    branch_en = 0; branch_cond = 0; reg_wr_en = 0; mem_wr_en = 0; targ_addr = '0;
  endtask

  // Entered with the DUT in FETCH; returns in the next FETCH or in DONE.
  task automatic run_instr(input int k);
    vec_t v;
    int cyc, nreg, nmem, at_reg, at_mem;
    v = prog[k];
    start = v.start; ack = v.ack; load_inst = v.ld; store_inst = v.st; jump = v.jump;
    branch_en = v.br; branch_cond = v.cond; reg_wr_en = v.rwe; mem_wr_en = v.mwe;
    targ_addr = v.targ;
    tick();
    chk($sformatf("ir_load_one_cycle[%0d]", k), 32'(ir_load), 32'd0);
    cyc = 0; nreg = 0; nmem = 0; at_reg = -1; at_mem = -1;
    while (cyc < 30) begin
      if (reg_wr_gate) begin nreg++; at_reg = cyc; end
      if (mem_wr_gate) begin nmem++; at_mem = cyc; end
      tick();
      cyc++;
      if (ir_load || done) break;
    end
    if (cyc >= 30) chk($sformatf("timeout[%0d]", k), 32'(cyc), 32'd0);
    clear_decode();
    chk($sformatf("pc[%0d]", k), 32'(prog_ctr), 32'(v.exp_pc));
    chk($sformatf("reg_pulses[%0d]", k), nreg, v.exp_reg);
    chk($sformatf("reg_at[%0d]", k), at_reg, v.exp_reg_at);
    chk($sformatf("mem_pulses[%0d]", k), nmem, v.exp_mem);
    chk($sformatf("mem_at[%0d]", k), at_mem, v.exp_mem_at);
    chk($sformatf("exec_cycles[%0d]", k), cyc, v.exp_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //             s a l t j b c r m  targ    pc     nr ar nm am cy
    prog[0]  = mk(0,0,0,0,0,0,0,1,0, 10'h000, 10'h001, 1, 0, 0,-1, 1);
    prog[1]  = mk(0,0,0,0,0,0,0,1,0, 10'h000, 10'h002, 1, 0, 0,-1, 1);
    prog[2]  = mk(0,0,0,0,0,0,0,0,0, 10'h000, 10'h003, 0,-1, 0,-1, 1);
    prog[3]  = mk(0,0,0,0,1,0,0,0,0, 10'h02A, 10'h02A, 0,-1, 0,-1, 1);
    prog[4]  = mk(0,0,0,0,0,1,0,0,0, 10'h100, 10'h02B, 0,-1, 0,-1, 1);
    prog[5]  = mk(0,0,0,0,0,1,1,1,0, 10'h100, 10'h100, 1, 0, 0,-1, 1);
    prog[6]  = mk(1,0,1,0,0,0,0,1,0, 10'h000, 10'h101, 1, 3, 0,-1, 4);
    prog[7]  = mk(0,0,0,1,0,0,0,0,1, 10'h000, 10'h102, 0,-1, 1, 1, 4);
    prog[8]  = mk(0,0,0,1,0,0,0,1,1, 10'h000, 10'h103, 0,-1, 1, 1, 4);
    prog[9]  = mk(0,0,0,0,1,0,0,0,0, 10'h3FF, 10'h3FF, 0,-1, 0,-1, 1);
    prog[10] = mk(0,0,0,0,0,0,0,1,1, 10'h000, 10'h000, 1, 0, 0,-1, 1);
    prog[11] = mk(0,0,1,0,1,0,0,1,1, 10'h055, 10'h001, 1, 3, 0,-1, 4);
    prog[12] = mk(0,1,0,0,1,0,0,1,1, 10'h077, 10'h001, 0,-1, 0,-1, 1);
    prog[13] = mk(0,0,0,0,0,0,0,1,0, 10'h000, 10'h001, 1, 0, 0,-1, 1);
    prog[14] = mk(0,0,0,0,0,0,0,1,0, 10'h000, 10'h002, 1, 0, 0,-1, 1);
    prog[15] = mk(0,0,0,0,0,0,0,1,0, 10'h000, 10'h003, 1, 0, 0,-1, 1);
    prog[16] = mk(0,1,0,0,0,0,0,0,0, 10'h000, 10'h003, 0,-1, 0,-1, 1);

    clear_decode();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_pc", 32'(prog_ctr), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", {29'd0, ir_load, reg_wr_gate, mem_wr_gate}, 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);

    start = 1;
    tick();
    start = 0;
    chk("start_ir_load", 32'(ir_load), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_pc", 32'(prog_ctr), 32'h0);

    for (int k = 0; k <= 12; k++) run_instr(k);
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_busy", 32'(busy), 32'd0);
    chk("p1_instr_cnt", 32'(instr_cnt), 32'd13);
    chk("p1_cycle_cnt", 32'(cycle_cnt), 32'd38);

    tick(); tick(); tick();
    chk("done_hold", 32'(done), 32'd1);
    chk("done_pc_hold", 32'(prog_ctr), 32'h001);
    chk("done_cycle_hold", 32'(cycle_cnt), 32'd38);
    chk("done_no_strobe", {29'd0, ir_load, reg_wr_gate, mem_wr_gate}, 32'd0);

    start = 1;
    tick();
    start = 0;
    chk("restart_pc", 32'(prog_ctr), 32'h0);
    chk("restart_ir_load", 32'(ir_load), 32'd1);
    chk("restart_cycle_clr", 32'(cycle_cnt), 32'd0);
    chk("restart_instr_clr", 32'(instr_cnt), 32'd0);

    for (int k = 13; k <= 16; k++) run_instr(k);
    chk("p2_done", 32'(done), 32'd1);
    chk("p2_instr_cnt", 32'(instr_cnt), 32'd4);
    chk("p2_cycle_cnt", 32'(cycle_cnt), 32'd8);

    // Load interrupted by reset in its write-back MEM cycle.
    start = 1;
    tick();
    start = 0;
    load_inst = 1; reg_wr_en = 1;
    tick();
    tick();
    chk("ld_mem1_no_reg", 32'(reg_wr_gate), 32'd0);
    tick();
    tick();
    chk("ld_mem3_reg", 32'(reg_wr_gate), 32'd1);
    reset = 1;
    #1;
    chk("ld_rst_gates_reg", 32'(reg_wr_gate), 32'd0);
    tick();
    reset = 0;
    clear_decode();
    chk("ld_rst_busy", 32'(busy), 32'd0);
    chk("ld_rst_pc", 32'(prog_ctr), 32'h0);
    chk("ld_rst_instr_cnt", 32'(instr_cnt), 32'd0);
    tick();
    chk("ld_rst_idle", {30'd0, busy, done}, 32'd0);

    // Store interrupted by reset in MEM cycle 2.
    start = 1;
    tick();
    start = 0;
    store_inst = 1; mem_wr_en = 1;
    tick();
    tick();
    chk("st_mem1_mem", 32'(mem_wr_gate), 32'd1);
    tick();
    reset = 1;
    #1;
    chk("st_mem2_no_mem", 32'(mem_wr_gate), 32'd0);
    tick();
    reset = 0;
    tick();
    chk("st_rst_idle", {29'd0, busy, done, mem_wr_gate}, 32'd0);
    clear_decode();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
